// File: rtl/pwm_duty_ramp.sv
// Duty-cycle slew limiter for the PWM generator: latches a target duty and
// steps dc_out toward it by step_sz once every rate+1 enabled clocks.
module pwm_duty_ramp #(
   parameter int DC_MAX = 100,
   parameter int RATE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [6:0]        target_in,
   input  logic              target_load,
   input  logic [RATE_W-1:0] rate,
   input  logic [3:0]        step_sz,
   output logic [6:0]        dc_out,
   output logic              busy,
   output logic              done,
   output logic              clamp_err
);

   // UP and DOWN share bit 1 so busy is a single flop output, glitch-free.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b10,
      DOWN = 2'b11
   } state_t;

   localparam logic [6:0] DC_MAX_V = 7'(DC_MAX);

   state_t            state, state_nx;
   logic [6:0]        tgt_reg;
   logic [RATE_W-1:0] pcnt;
   logic              state_chg;
   logic              run;
   logic              tick;
   logic [3:0]        step_eff;
   logic [7:0]        up_sum;
   logic [7:0]        dn_diff;
   logic [6:0]        up_val;
   logic [6:0]        dn_val;
   logic              over_max;

   // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
   always_comb begin
      state_nx = state;
      if (tgt_reg > dc_out)
         state_nx = UP;
      else if (tgt_reg < dc_out)
         state_nx = DOWN;
      else
         state_nx = IDLE;
   end

   assign state_chg = (state_nx != state);
   // A tick is suppressed on a direction change so a stale min/max can't jump dc_out.
   assign run       = en && (state != IDLE) && !state_chg;
   assign tick      = run && (pcnt == rate);
   assign step_eff  = (step_sz == 4'd0) ? 4'd1 : step_sz;
   assign up_sum    = {1'b0, dc_out} + {4'b0000, step_eff};
   assign dn_diff   = {1'b0, dc_out} - {4'b0000, step_eff};
   assign up_val    = (up_sum > {1'b0, tgt_reg}) ? tgt_reg : up_sum[6:0];
   assign dn_val    = (dn_diff[7] || (dn_diff < {1'b0, tgt_reg})) ? tgt_reg : dn_diff[6:0];
   assign over_max  = (target_in > DC_MAX_V);
   assign busy      = state[1];

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tgt_reg   <= '0;
         dc_out    <= '0;
         pcnt      <= '0;
         done      <= 1'b0;
         clamp_err <= 1'b0;
      end else begin
         state     <= state_nx;
         done      <= (state != IDLE) && (state_nx == IDLE);
         clamp_err <= target_load && over_max;

         if (target_load)
            tgt_reg <= over_max ? DC_MAX_V : target_in;

         if (state_chg)
            pcnt <= '0;
         else if (run)
            pcnt <= tick ? '0 : pcnt + 1'b1;

         if (tick)
            dc_out <= (state == UP) ? up_val : dn_val;
      end
   end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: directed table, hand-written corner
// sequences and random stimulus, all compared against a behavioural model.
module tb_pwm_duty_ramp;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [6:0] target_in;
   logic       target_load;
   logic [7:0] rate;
   logic [3:0] step_sz;
   logic [6:0] dc_out;
   logic       busy;
   logic       done;
   logic       clamp_err;

   int n_tests = 0;
   int n_fail  = 0;

   pwm_duty_ramp #(.DC_MAX(100), .RATE_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .target_in  (target_in),
      .target_load(target_load),
      .rate       (rate),
      .step_sz    (step_sz),
      .dc_out     (dc_out),
      .busy       (busy),
      .done       (done),
      .clamp_err  (clamp_err)
   );

   always #5 clk = ~clk;

   // Reference model: direction is the sign of (target - duty); the duty moves
   // toward the target every rate+1 enabled clocks while that sign is stable.
   int m_dc, m_tgt, m_dir, m_cnt;
   bit m_done, m_clamp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_dc = 0; m_tgt = 0; m_dir = 0; m_cnt = 0; m_done = 0; m_clamp = 0;
   endtask

   task automatic model_update();
      int want, n_dc, n_cnt, s;
      if (reset) begin
         model_reset();
         return;
      end
      want  = (m_tgt > m_dc) ? 1 : ((m_tgt < m_dc) ? -1 : 0);
      n_dc  = m_dc;
      n_cnt = m_cnt;
      if (want != m_dir) begin
         n_cnt = 0;
      end else if (m_dir != 0 && en) begin
         if (m_cnt == int'(rate)) begin
            s     = (step_sz == 0) ? 1 : int'(step_sz);
            n_cnt = 0;
            if (m_dir > 0) n_dc = (m_dc + s > m_tgt) ? m_tgt : m_dc + s;
            else           n_dc = (m_dc - s < m_tgt) ? m_tgt : m_dc - s;
         end else begin
            n_cnt = (m_cnt + 1) % 256;
         end
      end
      m_done  = (m_dir != 0) && (want == 0);
      m_clamp = target_load && (int'(target_in) > 100);
      if (target_load) m_tgt = (int'(target_in) > 100) ? 100 : int'(target_in);
      m_dir = want;
      m_dc  = n_dc;
      m_cnt = n_cnt;
   endtask

   task automatic compare_all();
      check("dc_out",    dc_out,    m_dc);
      check("busy",      busy,      (m_dir != 0));
      check("done",      done,      m_done);
      check("clamp_err", clamp_err, m_clamp);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      cyc();
      reset       = 1'b0;
      target_load = 1'b0;
   endtask

   task automatic load(input int t);
      target_in   = 7'(t);
      target_load = 1'b1;
      cyc();
      target_load = 1'b0;
   endtask

   task automatic wait_dc(input int v, input string name);
      int k = 0;
      while (dc_out !== 7'(v) && k < 400) begin
         cyc();
         k++;
      end
      check(name, dc_out, v);
   endtask

   typedef struct {
      int tin;
      int rt;
      int st;
      int exp_dc;
      int exp_clamp;
      int exp_done;   // edge index after the load edge at which done pulses; 0 = never
   } vec_t;

   vec_t vecs[8];

   initial begin
      int e, first, limit, dn_cnt, jumps, prev, gap;

      reset = 1'b1; en = 1'b0; target_in = '0; target_load = 1'b0;
      rate = '0; step_sz = 4'd1;
      model_reset();

      vecs[0] = '{50,  0, 1,  50,  0, 52};
      vecs[1] = '{120, 0, 15, 100, 1, 9};
      vecs[2] = '{10,  0, 4,  10,  0, 5};
      vecs[3] = '{10,  0, 0,  10,  0, 12};
      vecs[4] = '{5,   3, 1,  5,   0, 22};
      vecs[5] = '{0,   2, 3,  0,   0, 0};
      vecs[6] = '{100, 1, 7,  100, 0, 32};
      vecs[7] = '{127, 5, 15, 100, 1, 44};

      #2;
      compare_all();
      cyc();
      cyc();

      // Directed table: each row starts from reset with en=1.
      for (int i = 0; i < 8; i++) begin
         do_reset();
         rate    = 8'(vecs[i].rt);
         step_sz = 4'(vecs[i].st);
         en      = 1'b1;
         load(vecs[i].tin);
         check("clamp_pulse", clamp_err, vecs[i].exp_clamp);
         e     = 0;
         first = 0;
         limit = (vecs[i].exp_done != 0) ? vecs[i].exp_done + 20 : 20;
         while (e < limit) begin
            cyc();
            e++;
            if (done && first == 0) first = e;
         end
         check("done_edge", first, vecs[i].exp_done);
         check("final_dc",  dc_out, vecs[i].exp_dc);
         check("final_idle", busy, 1'b0);
      end

      // First-transaction latency: busy at edge 1, first step at edge 2.
      do_reset();
      rate = 8'd0; step_sz = 4'd1; en = 1'b1;
      load(50);
      check("lat_busy_e0", busy, 1'b0);
      cyc();
      check("lat_busy_e1", busy, 1'b1);
      check("lat_dc_e1", dc_out, 0);
      cyc();
      check("lat_dc_e2", dc_out, 1);

      // Retarget mid-ramp: going up to 80, reach 40, then aim for 20.
      do_reset();
      rate = 8'd0; step_sz = 4'd1; en = 1'b1;
      load(80);
      wait_dc(39, "retarget_reach39");
      load(20);
      check("retarget_dc40", dc_out, 40);
      prev = 40; jumps = 0; dn_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         cyc();
         if (dc_out > 7'(prev)) jumps++;
         if (int'(dc_out) < prev - 1) jumps++;
         if (done) dn_cnt++;
         prev = int'(dc_out);
      end
      check("retarget_jumps", jumps, 0);
      check("retarget_dones", dn_cnt, 1);
      check("retarget_final", dc_out, 20);

      // en freeze: rate=3 spacing of 4 edges, stretched by 6 frozen edges.
      do_reset();
      rate = 8'd3; step_sz = 4'd1; en = 1'b1;
      load(5);
      wait_dc(2, "freeze_reach2");
      cyc();
      en = 1'b0;
      repeat (6) cyc();
      check("freeze_dc_held", dc_out, 2);
      en  = 1'b1;
      gap = 7;
      while (dc_out == 7'd2 && gap < 40) begin
         cyc();
         gap++;
      end
      check("freeze_gap", gap, 10);
      gap = 0;
      while (dc_out == 7'd3 && gap < 40) begin
         cyc();
         gap++;
      end
      check("resume_gap", gap, 4);

      // Load landing on the edge where the old target is reached: no done.
      do_reset();
      rate = 8'd0; step_sz = 4'd1; en = 1'b1;
      load(10);
      wait_dc(9, "settle_reach9");
      load(15);
      check("settle_busy", busy, 1'b1);
      dn_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (done) dn_cnt++;
      end
      check("settle_dones", dn_cnt, 1);
      check("settle_final", dc_out, 15);

      // Asynchronous reset mid-ramp, then no motion without a new load.
      do_reset();
      rate = 8'd0; step_sz = 4'd1; en = 1'b1;
      load(60);
      wait_dc(30, "rst_reach30");
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_dc", dc_out, 0);
      check("async_rst_busy", busy, 1'b0);
      model_reset();
      cyc();
      reset = 1'b0;
      repeat (10) cyc();
      check("post_rst_dc", dc_out, 0);

      // Random traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         en          = ($urandom_range(0, 7) != 0);
         target_load = ($urandom_range(0, 15) == 0);
         target_in   = 7'($urandom_range(0, 127));
         step_sz     = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0) rate = 8'($urandom_range(0, 3));
         reset       = ($urandom_range(0, 999) == 0);
         cyc();
      end
      reset = 1'b0;
      target_load = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
